// File: rtl/tank_move_ctl.sv
//------------------------------------------------------------------------------
// Module      : tank_move_ctl
// Description : Per-frame motion/orientation controller for one tank sprite.
//               Samples the direction keys on each vblank rising edge, delays
//               direction changes by ROT_FRAMES held frames, steps the sprite
//               and clamps its bounding box to the visible screen.
//               Optional build macro: TANK_MOVE_ACCEL_EN (step acceleration).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tank_move_ctl #(
  parameter int SCREEN_W   = 800,
  parameter int SCREEN_H   = 600,
  parameter int INIT_X     = 376,
  parameter int INIT_Y     = 500,
  parameter int STEP       = 2,
  parameter int ROT_FRAMES = 8,
  parameter int MAX_STEP   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       vblnk_in,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  output logic [9:0] posX,
  output logic [9:0] posY,
  output logic [1:0] direction_tank,
  output logic       moving,
  output logic       turning
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TURNING = 2'd1,
    S_MOVING  = 2'd2
  } state_t;

  localparam logic [1:0]  c_DIR_UP    = 2'd0;
  localparam logic [1:0]  c_DIR_DOWN  = 2'd1;
  localparam logic [1:0]  c_DIR_LEFT  = 2'd2;
  localparam logic [1:0]  c_DIR_RIGHT = 2'd3;
  // Bounding-box limits: vertical sprite is 48x64, horizontal is 64x48
  localparam logic [10:0] c_X_MAX_V   = 11'(SCREEN_W - 48);
  localparam logic [10:0] c_Y_MAX_V   = 11'(SCREEN_H - 64);
  localparam logic [10:0] c_X_MAX_H   = 11'(SCREEN_W - 64);
  localparam logic [10:0] c_Y_MAX_H   = 11'(SCREEN_H - 48);
  localparam int          c_CNT_W     = (ROT_FRAMES < 2) ? 1 : $clog2(ROT_FRAMES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_DONE = c_CNT_W'(ROT_FRAMES);

  // A step ceiling below the base step has no meaningful acceleration range;
  // such a configuration elaborates no extra logic and acceleration pins at STEP.
  if (MAX_STEP < STEP) begin : g_step_ceiling_below_base
  end

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_turn_cnt, w_turn_cnt_nxt;
  logic [1:0]           r_tgt_dir, w_tgt_dir_nxt;
  logic [1:0]           r_dir, w_dir_nxt;
  logic [9:0]           r_posx, w_posx_nxt;
  logic [9:0]           r_posy, w_posy_nxt;
  logic                 r_moving, r_turning;
  logic                 r_vblnk_prev;

  logic                 w_tick;
  logic                 w_req_valid;
  logic [1:0]           w_req_dir;
  logic [9:0]           w_s;
  logic [10:0]          w_sum_x, w_sum_y;
  logic [9:0]           w_x_vert;
  logic [9:0]           w_step_x, w_step_y;
  logic                 w_step_sat;
  logic [10:0]          w_rot_xlim, w_rot_ylim;
  logic [9:0]           w_rot_x, w_rot_y;
  logic                 w_do_step;

`ifdef TANK_MOVE_ACCEL_EN
  logic [9:0]           r_step, w_step_nxt;
  assign w_s = r_step;
`else
  assign w_s = 10'(STEP);
`endif

  assign w_tick      = vblnk_in & ~r_vblnk_prev & enable;
  assign w_req_valid = key_up | key_down | key_left | key_right;

  // Fixed key priority: up > down > left > right
  always_comb begin
    w_req_dir = c_DIR_RIGHT;
    if (key_up)         w_req_dir = c_DIR_UP;
    else if (key_down)  w_req_dir = c_DIR_DOWN;
    else if (key_left)  w_req_dir = c_DIR_LEFT;
  end

  // Candidate position after one step in the committed direction, saturating at edges
  always_comb begin
    w_sum_x    = {1'b0, r_posx} + {1'b0, w_s};
    w_sum_y    = {1'b0, r_posy} + {1'b0, w_s};
    w_x_vert   = ({1'b0, r_posx} > c_X_MAX_V) ? c_X_MAX_V[9:0] : r_posx;
    w_step_x   = r_posx;
    w_step_y   = r_posy;
    w_step_sat = 1'b0;
    case (r_dir)
      c_DIR_UP: begin
        w_step_x = w_x_vert;
        if (r_posy >= w_s) begin
          w_step_y = r_posy - w_s;
        end else begin
          w_step_y   = '0;
          w_step_sat = 1'b1;
        end
      end
      c_DIR_DOWN: begin
        w_step_x = w_x_vert;
        if (w_sum_y > c_Y_MAX_V) begin
          w_step_y   = c_Y_MAX_V[9:0];
          w_step_sat = 1'b1;
        end else begin
          w_step_y = w_sum_y[9:0];
        end
      end
      c_DIR_LEFT: begin
        if (r_posx >= w_s) begin
          w_step_x = r_posx - w_s;
        end else begin
          w_step_x   = '0;
          w_step_sat = 1'b1;
        end
      end
      default: begin
        if (w_sum_x > c_X_MAX_H) begin
          w_step_x   = c_X_MAX_H[9:0];
          w_step_sat = 1'b1;
        end else begin
          w_step_x = w_sum_x[9:0];
        end
      end
    endcase
  end

  // Position after committing to the target orientation (box may change shape)
  always_comb begin
    w_rot_xlim = r_tgt_dir[1] ? c_X_MAX_H : c_X_MAX_V;
    w_rot_ylim = r_tgt_dir[1] ? c_Y_MAX_H : c_Y_MAX_V;
    w_rot_x    = ({1'b0, r_posx} > w_rot_xlim) ? w_rot_xlim[9:0] : r_posx;
    w_rot_y    = ({1'b0, r_posy} > w_rot_ylim) ? w_rot_ylim[9:0] : r_posy;
  end

  // Next-state and datapath update; nothing changes outside a tick
  always_comb begin
    w_state_nxt    = r_state;
    w_turn_cnt_nxt = r_turn_cnt;
    w_tgt_dir_nxt  = r_tgt_dir;
    w_dir_nxt      = r_dir;
    w_posx_nxt     = r_posx;
    w_posy_nxt     = r_posy;
    w_do_step      = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_req_valid) begin
            if (w_req_dir == r_dir) begin
              w_state_nxt = S_MOVING;
              w_do_step   = 1'b1;
            end else begin
              w_state_nxt    = S_TURNING;
              w_turn_cnt_nxt = c_CNT_W'(1);
              w_tgt_dir_nxt  = w_req_dir;
            end
          end
        end
        S_TURNING: begin
          if (!w_req_valid) begin
            w_state_nxt    = S_IDLE;
            w_turn_cnt_nxt = '0;
          end else if (w_req_dir == r_dir) begin
            w_state_nxt    = S_MOVING;
            w_turn_cnt_nxt = '0;
            w_do_step      = 1'b1;
          end else if (w_req_dir != r_tgt_dir) begin
            w_tgt_dir_nxt  = w_req_dir;
            w_turn_cnt_nxt = c_CNT_W'(1);
          end else if (r_turn_cnt == c_CNT_DONE) begin
            w_dir_nxt      = r_tgt_dir;
            w_posx_nxt     = w_rot_x;
            w_posy_nxt     = w_rot_y;
            w_state_nxt    = S_MOVING;
            w_turn_cnt_nxt = '0;
          end else begin
            w_turn_cnt_nxt = r_turn_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          if (!w_req_valid) begin
            w_state_nxt = S_IDLE;
          end else if (w_req_dir == r_dir) begin
            w_do_step = 1'b1;
          end else begin
            w_state_nxt    = S_TURNING;
            w_turn_cnt_nxt = c_CNT_W'(1);
            w_tgt_dir_nxt  = w_req_dir;
          end
        end
      endcase
      if (w_do_step) begin
        w_posx_nxt = w_step_x;
        w_posy_nxt = w_step_y;
      end
    end
  end

`ifdef TANK_MOVE_ACCEL_EN
  // Step size grows while moving, drops back to base on leaving MOVING or hitting an edge
  always_comb begin
    w_step_nxt = r_step;
    if (w_state_nxt != S_MOVING) begin
      w_step_nxt = 10'(STEP);
    end else if (w_do_step) begin
      if (w_step_sat)                      w_step_nxt = 10'(STEP);
      else if (r_step >= 10'(MAX_STEP))    w_step_nxt = r_step;
      else                                 w_step_nxt = r_step + 10'd1;
    end
  end

  // Step size register
  always_ff @(posedge clk) begin
    if (rst) r_step <= 10'(STEP);
    else     r_step <= w_step_nxt;
  end
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_turn_cnt   <= '0;
      r_tgt_dir    <= c_DIR_UP;
      r_dir        <= c_DIR_UP;
      r_posx       <= 10'(INIT_X);
      r_posy       <= 10'(INIT_Y);
      r_moving     <= 1'b0;
      r_turning    <= 1'b0;
      r_vblnk_prev <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_turn_cnt   <= w_turn_cnt_nxt;
      r_tgt_dir    <= w_tgt_dir_nxt;
      r_dir        <= w_dir_nxt;
      r_posx       <= w_posx_nxt;
      r_posy       <= w_posy_nxt;
      r_moving     <= (w_state_nxt == S_MOVING);
      r_turning    <= (w_state_nxt == S_TURNING);
      r_vblnk_prev <= vblnk_in;
    end
  end

  assign posX           = r_posx;
  assign posY           = r_posy;
  assign direction_tank = r_dir;
  assign moving         = r_moving;
  assign turning        = r_turning;

endmodule

`default_nettype wire
